// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues byte addresses to a synchronous-read
// instruction memory, presents the returned word with its address, holds
// the fetch during hazard stalls and inserts two bubbles on a redirect.
module inst_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        jump_valid,
   input  logic [15:0] jump_target,
   input  logic [31:0] mem_inst,
   output logic [15:0] pc_addr,
   output logic [31:0] inst_out,
   output logic        inst_valid,
   output logic [15:0] inst_pc,
   output logic        jump_stall_en,
   output logic        stall_en,
   output logic [15:0] bubble_count
);

   typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetchState_t;

   fetchState_t state;
   fetchState_t stateNext;

   // pcReg is the next address to issue; respPc/respValid describe the
   // word currently arriving on mem_inst.
   logic [15:0] pcReg;
   logic [15:0] pcRegNext;
   logic [15:0] respPc;
   logic [15:0] respPcNext;
   logic        respValid;
   logic        respValidNext;
   logic [15:0] bubbleCount;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state and next fetch values; a redirect beats a stall, and any
   // unstalled cycle issues pcReg and moves to RUN whatever the state.
   always_comb begin
      stateNext     = state;
      pcRegNext     = pcReg;
      respPcNext    = respPc;
      respValidNext = respValid;
      if (jump_valid) begin
         pcRegNext     = {jump_target[15:2], 2'b00};
         respValidNext = 1'b0;
         stateNext     = FLUSH;
      end else if (!stall) begin
         respPcNext    = pcReg;
         pcRegNext     = pcReg + 16'd4;
         respValidNext = 1'b1;
         stateNext     = RUN;
      end
   end

   // Fetch address / response tracking registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcReg     <= RESET_PC;
         respPc    <= RESET_PC;
         respValid <= 1'b0;
      end else begin
         pcReg     <= pcRegNext;
         respPc    <= respPcNext;
         respValid <= respValidNext;
      end
   end

   // Bubble counter, saturating so long runs never wrap back to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubbleCount <= 16'h0000;
      end else if (jump_stall_en && (bubbleCount != 16'hFFFF)) begin
         bubbleCount <= bubbleCount + 16'd1;
      end
   end

   // Outputs; a stalled RUN re-issues respPc so mem_inst keeps its word.
   always_comb begin
      stall_en      = stall & ~jump_valid & (state == RUN);
      jump_stall_en = jump_valid | (state == FLUSH);
      inst_valid    = (state == RUN) & respValid & ~jump_valid;
      inst_out      = inst_valid ? mem_inst : NOP_INST;
      inst_pc       = respPc;
      pc_addr       = stall_en ? respPc : pcReg;
      bubble_count  = bubbleCount;
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: synchronous memory model returning
// 32'hA000_0000 | address, with a queue of expected instruction addresses.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        jump_valid;
   logic [15:0] jump_target;
   logic [31:0] mem_inst;
   logic [15:0] pc_addr;
   logic [31:0] inst_out;
   logic        inst_valid;
   logic [15:0] inst_pc;
   logic        jump_stall_en;
   logic        stall_en;
   logic [15:0] bubble_count;

   int checks = 0;
   int errors = 0;
   logic [15:0] sb[$];
   logic [15:0] e;

   localparam logic [31:0] NOP = 32'h00000013;

   inst_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .jump_valid(jump_valid),
      .jump_target(jump_target), .mem_inst(mem_inst), .pc_addr(pc_addr),
      .inst_out(inst_out), .inst_valid(inst_valid), .inst_pc(inst_pc),
      .jump_stall_en(jump_stall_en), .stall_en(stall_en), .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory.
   always_ff @(posedge clk) mem_inst <= {16'hA000, pc_addr};

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   // Drive one cycle's inputs just after the falling edge and settle.
   task automatic cyc(input logic s, input logic j, input logic [15:0] t);
      @(negedge clk);
      stall = s; jump_valid = j; jump_target = t;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b1; jump_valid = 1'b1; jump_target = 16'h1234;
      #12;
      checks++; if (pc_addr !== 16'h0000) begin errors++; $display("FAIL rst_pc_addr got=%h exp=0000", pc_addr); end
      checks++; if (inst_out !== NOP) begin errors++; $display("FAIL rst_inst_out got=%h exp=%h", inst_out, NOP); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
      checks++; if (inst_pc !== 16'h0000) begin errors++; $display("FAIL rst_inst_pc got=%h exp=0000", inst_pc); end
      checks++; if (stall_en !== 1'b0) begin errors++; $display("FAIL rst_stall_en got=%b exp=0", stall_en); end
      checks++; if (jump_stall_en !== 1'b1) begin errors++; $display("FAIL rst_jse_hi got=%b exp=1", jump_stall_en); end
      checks++; if (bubble_count !== 16'h0000) begin errors++; $display("FAIL rst_bubbles got=%h exp=0000", bubble_count); end
      jump_valid = 1'b0; #1;
      checks++; if (jump_stall_en !== 1'b0) begin errors++; $display("FAIL rst_jse_lo got=%b exp=0", jump_stall_en); end
      @(negedge clk);
      stall = 1'b0; jump_valid = 1'b0; jump_target = 16'h0000; rst_n = 1'b1; #1;
      checks++; if (pc_addr !== 16'h0000) begin errors++; $display("FAIL boot_pc_addr got=%h exp=0000", pc_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got=%b exp=0", inst_valid); end
   endtask

   task automatic test_fetch();
      for (int i = 0; i < 2; i++) begin
         sb.push_back(16'(i * 4));
         cyc(1'b0, 1'b0, 16'h0000);
         checks++; if (pc_addr !== 16'(i * 4 + 4)) begin errors++; $display("FAIL fetch_pc_addr got=%h exp=%h", pc_addr, 16'(i * 4 + 4)); end
         if (inst_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (inst_pc !== e || inst_out !== {16'hA000, e}) begin errors++; $display("FAIL fetch_inst got=%h/%h exp=%h/%h", inst_pc, inst_out, e, {16'hA000, e}); end
         end
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL fetch_missing pending=%0d exp=0", sb.size()); sb.delete(); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         sb.push_back(16'h0008);
         cyc(1'b1, 1'b0, 16'h0000);
         checks++; if (pc_addr !== 16'h0008) begin errors++; $display("FAIL stall_pc_addr got=%h exp=0008", pc_addr); end
         checks++; if (stall_en !== 1'b1) begin errors++; $display("FAIL stall_en got=%b exp=1", stall_en); end
         if (inst_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (inst_pc !== e || inst_out !== {16'hA000, e}) begin errors++; $display("FAIL stall_inst got=%h/%h exp=%h/%h", inst_pc, inst_out, e, {16'hA000, e}); end
         end
      end
      // Release cycle still shows 0008, then 000C follows.
      for (int i = 0; i < 2; i++) begin
         sb.push_back(16'h0008 + 16'(i * 4));
         cyc(1'b0, 1'b0, 16'h0000);
         checks++; if (stall_en !== 1'b0) begin errors++; $display("FAIL unstall_en got=%b exp=0", stall_en); end
         if (inst_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (inst_pc !== e || inst_out !== {16'hA000, e}) begin errors++; $display("FAIL unstall_inst got=%h/%h exp=%h/%h", inst_pc, inst_out, e, {16'hA000, e}); end
         end
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_missing pending=%0d exp=0", sb.size()); sb.delete(); end
   endtask

   // Redirect with optional same-cycle stall; checks two bubbles then target stream.
   task automatic test_jump(input logic withStall, input logic [15:0] target, input logic [15:0] expBubbles);
      logic [15:0] base;
      base = {target[15:2], 2'b00};
      for (int i = 0; i < 2; i++) begin
         cyc(withStall && i == 0, i == 0, target);
         checks++; if (inst_valid !== 1'b0 || inst_out !== NOP) begin errors++; $display("FAIL jump_bubble%0d got=%b/%h exp=0/%h", i, inst_valid, inst_out, NOP); end
         checks++; if (jump_stall_en !== 1'b1) begin errors++; $display("FAIL jump_jse%0d got=%b exp=1", i, jump_stall_en); end
         checks++; if (stall_en !== 1'b0) begin errors++; $display("FAIL jump_stall_en%0d got=%b exp=0", i, stall_en); end
      end
      checks++; if (pc_addr !== base) begin errors++; $display("FAIL jump_pc_addr got=%h exp=%h", pc_addr, base); end
      for (int i = 0; i < 2; i++) begin
         sb.push_back(base + 16'(i * 4));
         cyc(1'b0, 1'b0, 16'h0000);
         checks++; if (jump_stall_en !== 1'b0) begin errors++; $display("FAIL jump_jse_after got=%b exp=0", jump_stall_en); end
         if (inst_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (inst_pc !== e || inst_out !== {16'hA000, e}) begin errors++; $display("FAIL jump_inst got=%h/%h exp=%h/%h", inst_pc, inst_out, e, {16'hA000, e}); end
         end
      end
      checks++; if (bubble_count !== expBubbles) begin errors++; $display("FAIL jump_bubbles got=%0d exp=%0d", bubble_count, expBubbles); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL jump_missing pending=%0d exp=0", sb.size()); sb.delete(); end
   endtask

   task automatic test_reset_flush();
      cyc(1'b0, 1'b1, 16'h0300);
      cyc(1'b1, 1'b0, 16'h0000);
      checks++; if (jump_stall_en !== 1'b1) begin errors++; $display("FAIL rf_in_flush got=%b exp=1", jump_stall_en); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (pc_addr !== 16'h0000 || inst_pc !== 16'h0000) begin errors++; $display("FAIL rf_pcs got=%h/%h exp=0000/0000", pc_addr, inst_pc); end
      checks++; if (inst_valid !== 1'b0 || inst_out !== NOP) begin errors++; $display("FAIL rf_inst got=%b/%h exp=0/%h", inst_valid, inst_out, NOP); end
      checks++; if (jump_stall_en !== 1'b0 || stall_en !== 1'b0) begin errors++; $display("FAIL rf_flags got=%b/%b exp=0/0", jump_stall_en, stall_en); end
      checks++; if (bubble_count !== 16'h0000) begin errors++; $display("FAIL rf_bubbles got=%h exp=0000", bubble_count); end
      @(negedge clk);
      stall = 1'b0; rst_n = 1'b1; #1;
      sb.push_back(16'h0000);
      cyc(1'b0, 1'b0, 16'h0000);
      if (inst_valid === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         checks++; if (inst_pc !== e || inst_out !== {16'hA000, e}) begin errors++; $display("FAIL rf_first got=%h/%h exp=%h/%h", inst_pc, inst_out, e, {16'hA000, e}); end
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL rf_missing pending=%0d exp=0", sb.size()); sb.delete(); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_stall();
      test_jump(1'b0, 16'h0102, 16'd2);
      test_jump(1'b1, 16'h0203, 16'd4);
      test_jump(1'b0, 16'hFFFC, 16'd6);
      test_reset_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
